serial_word_pair_serializer: RTL and testbench

Upstream feeder for the MSB-first serial comparator. It accepts a pair of W-bit parallel words over a valid/ready handshake and shifts both out MSB-first, one bit per clock, on the comparator's `a`/`b` inputs. It generates the comparator's per-word re-initialisation pulse, so consecutive words stream back-to-back with no idle gap. Optionally, it captures the comparator's verdict on the final bit.

---
 rtl/serial_word_pair_serializer.sv | 105 ++++++++++
 tb/tb_serial_word_pair_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_pair_serializer.sv
// MSB-first serializer feeding a word pair to the bit-serial comparator, with per-word comparator re-init.
// Optional verdict capture is enabled by defining SERIAL_WORD_PAIR_RESULT_CAPTURE_EN.
module serial_word_pair_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         a,
    output logic         b,
    output logic         bit_valid,
    output logic         bit_last,
    output logic         cmp_rst
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
    ,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    input  logic         cmp_gt,
    output logic         res_valid,
    output logic         res_lt,
    output logic         res_eq,
    output logic         res_gt
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    sa_reg, sa_next;
    logic [W-1:0]    sb_reg, sb_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            busy;
    logic            accept;

    assign busy      = (state_reg == SHIFT);
    assign in_ready  = !busy || (cnt_reg == '0);
    assign accept    = in_valid && in_ready;

    assign a         = sa_reg[W-1] & busy;
    assign b         = sb_reg[W-1] & busy;
    assign bit_valid = busy;
    assign bit_last  = busy && (cnt_reg == '0);
    // Holding the comparator in reset while idle and on each last bit gives every word a fresh start.
    assign cmp_rst   = !busy || bit_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        cnt_next   = cnt_reg;
        if (accept) begin
            // A new pair on the last-bit edge takes priority, so words stream without a gap.
            sa_next    = in_a;
            sb_next    = in_b;
            cnt_next   = CW'(W - 1);
            state_next = SHIFT;
        end else if (state_reg == SHIFT) begin
            if (cnt_reg != '0) begin
                sa_next  = {sa_reg[W-2:0], 1'b0};
                sb_next  = {sb_reg[W-2:0], 1'b0};
                cnt_next = cnt_reg - 1'b1;
            end else begin
                state_next = IDLE;
            end
        end
    end

`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_lt    <= 1'b0;
            res_eq    <= 1'b0;
            res_gt    <= 1'b0;
        end else if (bit_last) begin
            res_valid <= 1'b1;
            res_lt    <= cmp_lt;
            res_eq    <= cmp_eq;
            res_gt    <= cmp_gt;
        end else begin
            res_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_pair_serializer.sv
// Self-checking bench: word-level reference model compared every cycle, plus directed literal checks.
module tb_serial_word_pair_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         a;
    logic         b;
    logic         bit_valid;
    logic         bit_last;
    logic         cmp_rst;
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
    logic         cmp_lt, cmp_eq, cmp_gt;
    logic         res_valid, res_lt, res_eq, res_gt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_word_pair_serializer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .a         (a),
        .b         (b),
        .bit_valid (bit_valid),
        .bit_last  (bit_last),
        .cmp_rst   (cmp_rst)
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
        ,
        .cmp_lt    (cmp_lt),
        .cmp_eq    (cmp_eq),
        .cmp_gt    (cmp_gt),
        .res_valid (res_valid),
        .res_lt    (res_lt),
        .res_eq    (res_eq),
        .res_gt    (res_gt)
`endif
    );

`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
    // Stand-in for the MSB-first comparator: first differing bit decides, cmp_rst returns it to equal.
    logic lt_s, gt_s;
    always @(posedge clk or posedge rst) begin
        if (rst || cmp_rst) begin
            lt_s <= 1'b0;
            gt_s <= 1'b0;
        end else if (bit_valid && !lt_s && !gt_s && (a != b)) begin
            gt_s <= a;
            lt_s <= b;
        end
    end
    assign cmp_gt = gt_s | (!lt_s & !gt_s & a & !b);
    assign cmp_lt = lt_s | (!lt_s & !gt_s & !a & b);
    assign cmp_eq = !cmp_lt & !cmp_gt;
`endif

    // Reference model: current word pair plus the bit position being presented.
    logic         m_busy;
    logic [W-1:0] m_a, m_b;
    int           m_pos;
    logic         m_res_valid, m_lt, m_eq, m_gt;

    always @(posedge clk or posedge rst) begin
        logic last, acc;
        if (rst) begin
            m_busy = 1'b0; m_a = '0; m_b = '0; m_pos = 0;
            m_res_valid = 1'b0; m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
        end else begin
            last = m_busy && (m_pos == 0);
            acc  = in_valid && (!m_busy || m_pos == 0);
            if (last) begin
                m_res_valid = 1'b1;
                m_lt = (m_a < m_b);
                m_eq = (m_a == m_b);
                m_gt = (m_a > m_b);
            end else begin
                m_res_valid = 1'b0;
            end
            if (acc) begin
                m_a = in_a; m_b = in_b; m_pos = W - 1; m_busy = 1'b1;
            end else if (m_busy) begin
                if (m_pos == 0) m_busy = 1'b0;
                else m_pos = m_pos - 1;
            end
        end
    end

    function automatic logic [5:0] model_outs();
        logic last;
        last = m_busy && (m_pos == 0);
        return {m_busy & m_a[m_pos], m_busy & m_b[m_pos], m_busy, last,
                !m_busy || last, !m_busy || m_pos == 0};
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [5:0] exp_o, act_o;
        exp_o = model_outs();
        act_o = {a, b, bit_valid, bit_last, cmp_rst, in_ready};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL model_stream t=%0t {a,b,bit_valid,bit_last,cmp_rst,in_ready} got=%b expected=%b",
                     $time, act_o, exp_o);
        end
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
        checks++;
        if (res_valid !== m_res_valid ||
            (m_res_valid && {res_lt, res_eq, res_gt} !== {m_lt, m_eq, m_gt})) begin
            errors++;
            $display("FAIL model_result t=%0t valid/lt/eq/gt got=%b%b%b%b expected=%b%b%b%b",
                     $time, res_valid, res_lt, res_eq, res_gt, m_res_valid, m_lt, m_eq, m_gt);
        end
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp_v);
        end else begin
            $display("check %s t=%0t value=%0h", name, $time, act);
        end
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {a, b, bit_valid, bit_last, cmp_rst, in_ready}, 32'b000011);
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
        check({name, "_res"}, {res_valid, res_lt, res_eq, res_gt}, 32'b0000);
`endif
    endtask

    task automatic offer(input logic [W-1:0] wa, input logic [W-1:0] wb);
        in_valid = 1'b1; in_a = wa; in_b = wb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] wa, wb, wc;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        #12;
        check_reset_outs("reset_initial");
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Single word A5 vs A3
        wa = 8'hA5; wb = 8'hA3;
        offer(wa, wb);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("single_a_c%0d", c), a, wa[8-c]);
            check($sformatf("single_b_c%0d", c), b, wb[8-c]);
            check($sformatf("single_last_rst_c%0d", c), {bit_last, cmp_rst}, (c == 8) ? 2'b11 : 2'b00);
        end
        @(negedge clk);
        check("single_idle_c9", bit_valid, 1'b0);
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
        check("single_res_c9", {res_valid, res_lt, res_eq, res_gt}, 4'b1001);
`endif
        @(posedge clk); #1;

        // Back-to-back 10/20 then 3C/3C
        offer(8'h10, 8'h20);
        @(posedge clk); #1 offer(8'h3C, 8'h3C);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), in_ready, (c == 8) ? 1'b1 : 1'b0);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        wc = 8'h3C;
        for (int c = 9; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("b2b_word2_c%0d", c), {bit_valid, a, b}, {1'b1, wc[16-c], wc[16-c]});
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
            if (c == 9) check("b2b_res_lt_c9", {res_valid, res_lt, res_eq, res_gt}, 4'b1100);
`endif
        end
        @(negedge clk);
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
        check("b2b_res_eq_c17", {res_valid, res_lt, res_eq, res_gt}, 4'b1010);
`endif
        check("b2b_idle_c17", bit_valid, 1'b0);
        @(posedge clk); #1;

        // Backpressure: second pair offered from cycle 3
        offer(8'hA5, 8'hA3);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 3) offer(8'h5A, 8'hC3);
            @(negedge clk);
            check($sformatf("bp_a_c%0d", c), a, wa[8-c]);
            if (c >= 3) check($sformatf("bp_ready_c%0d", c), in_ready, (c == 8) ? 1'b1 : 1'b0);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_msb_c9", {bit_valid, a, b}, 3'b101);
        repeat (10) @(posedge clk);
        #1;

        // Reset in the middle of a word
        offer(8'hF0, 8'h0F);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outs("midword_reset");
        @(negedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 offer(8'h01, 8'h02);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("after_reset_accept", {bit_valid, a, b}, 3'b100);
        repeat (10) @(posedge clk);
        #1;

        // Idle for 20 cycles
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("idle_c%0d", c), {bit_valid, a, b, cmp_rst}, 4'b0001);
`ifdef SERIAL_WORD_PAIR_RESULT_CAPTURE_EN
            check($sformatf("idle_res_c%0d", c), res_valid, 1'b0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
